// File: rtl/sub_16b_serial.sv
// ---------------------------------------------------------------------------
// sub_16b_serial
//
// Computes z = x - y (mod 2^16) one 4-bit nibble per clock, LSB nibble first,
// rippling a single borrow bit between nibbles.
//
// Sequence: IDLE -> CALC (4 edges) -> DONE (1 edge) -> IDLE.
// Start is taken only in IDLE. The DONE edge publishes z and every flag
// together and raises done for exactly one cycle.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-high reset
//   start     in   begin an operation (sampled only in IDLE)
//   x, y      in   16-bit minuend / subtrahend, captured on the accepted start
//   z         out  registered difference x - y mod 2^16
//   sign      out  z[15]
//   zero      out  z == 0
//   carry     out  borrow out of bit 15 (x < y unsigned)
//   parity    out  even parity of z (1 when z has an even number of ones)
//   overflow  out  signed overflow of the subtraction
//   busy      out  operation in progress, held through the done cycle
//   done      out  one-cycle pulse, result and flags valid
// ---------------------------------------------------------------------------
module sub_16b_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] z,
  output logic        sign,
  output logic        zero,
  output logic        carry,
  output logic        parity,
  output logic        overflow,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] xr_q;
  logic [15:0] yr_q;
  logic [15:0] res_q;      // nibble-wise assembled difference
  logic [1:0]  cnt_q;
  logic        borrow_q;

  logic [15:0] z_q;
  logic        sign_q;
  logic        zero_q;
  logic        carry_q;
  logic        parity_q;
  logic        overflow_q;
  logic        busy_q;
  logic        done_q;

  // Current nibble slice and its 5-bit difference; bit 4 is the borrow out.
  logic [3:0]  x_nib_d;
  logic [3:0]  y_nib_d;
  logic [4:0]  diff_d;

  always_comb begin
    x_nib_d = xr_q[{cnt_q, 2'b00} +: 4];
    y_nib_d = yr_q[{cnt_q, 2'b00} +: 4];
    diff_d  = {1'b0, x_nib_d} - {1'b0, y_nib_d} - {4'b0000, borrow_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      xr_q       <= 16'h0000;
      yr_q       <= 16'h0000;
      res_q      <= 16'h0000;
      cnt_q      <= 2'd0;
      borrow_q   <= 1'b0;
      z_q        <= 16'h0000;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      parity_q   <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // busy drops here, one cycle after DONE, unless a new start
          // is taken on this very edge (back-to-back operation).
          busy_q <= start;
          if (start) begin
            xr_q     <= x;
            yr_q     <= y;
            cnt_q    <= 2'd0;
            borrow_q <= 1'b0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          busy_q                       <= 1'b1;
          res_q[{cnt_q, 2'b00} +: 4]   <= diff_d[3:0];
          borrow_q                     <= diff_d[4];
          cnt_q                        <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // Flags come from the full result and the captured operands;
          // the final borrow is the borrow out of bit 15.
          z_q        <= res_q;
          sign_q     <= res_q[15];
          zero_q     <= (res_q == 16'h0000);
          carry_q    <= borrow_q;
          parity_q   <= ~^res_q;
          overflow_q <= (xr_q[15] ^ yr_q[15]) & (res_q[15] ^ xr_q[15]);
          done_q     <= 1'b1;
          busy_q     <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign z        = z_q;
  assign sign     = sign_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign parity   = parity_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sub_16b_serial.sv
// ---------------------------------------------------------------------------
// tb_sub_16b_serial
//
// Stimulus pushes the expected result of every accepted operation into a
// scoreboard queue; an independent monitor on the falling edge pops and
// compares whenever done is high, and checks that outputs hold otherwise.
// ---------------------------------------------------------------------------
module tb_sub_16b_serial;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] z;
  logic        sign;
  logic        zero;
  logic        carry;
  logic        parity;
  logic        overflow;
  logic        busy;
  logic        done;

  sub_16b_serial dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x        (x),
    .y        (y),
    .z        (z),
    .sign     (sign),
    .zero     (zero),
    .carry    (carry),
    .parity   (parity),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] z;
    logic        sign;
    logic        zero;
    logic        carry;
    logic        parity;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t hold;
  bit   hold_valid = 1'b0;
  int   cyc = 0;
  bit   rst_applied = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_applied = rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Reference: plain integer subtraction and the flag definitions.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int dcyc);
    exp_t e;
    int   d;
    d = int'(a) - int'(b);
    if (d < 0) d = d + 65536;
    e.z      = d[15:0];
    e.sign   = (d >= 32768);
    e.zero   = (d == 0);
    e.carry  = (a < b);
    e.parity = ($countones(e.z) % 2 == 0);
    e.ovf    = (a[15] != b[15]) && (e.sign != a[15]);
    e.cyc    = dcyc;
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_applied) begin
      check("reset_outputs", {11'd0, z, sign, zero, carry, parity, overflow, busy, done}, 32'd0);
      hold       = model(16'h0, 16'h0, 0);
      hold.zero  = 1'b0;
      hold.parity = 1'b0;
      hold_valid = 1'b1;
    end else if (hold_valid) begin
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done cyc=%0d actual=done required=no_done z=%0h", cyc, z);
        end else begin
          e = sb.pop_front();
          $display("op result cyc=%0d z=%0h exp=%0h flags=%b%b%b%b%b", cyc, z, e.z,
                   sign, zero, carry, parity, overflow);
          check("z", {16'd0, z}, {16'd0, e.z});
          check("flags", {27'd0, sign, zero, carry, parity, overflow},
                {27'd0, e.sign, e.zero, e.carry, e.parity, e.ovf});
          check("done_cycle", cyc, e.cyc);
          check("busy_at_done", {31'd0, busy}, 32'd1);
          hold = e;
        end
      end else begin
        check("hold", {11'd0, z, sign, zero, carry, parity, overflow},
              {11'd0, hold.z, hold.sign, hold.zero, hold.carry, hold.parity, hold.ovf});
      end
    end
  end

  // Single operation; returns in the done cycle.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    x = a; y = b; start = 1'b1;
    sb.push_back(model(a, b, cyc + 6));
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    x = 16'($urandom);
    y = 16'($urandom);
    repeat (5) @(posedge clk);
    #1;
  endtask

  logic [15:0] dx [4] = '{16'h8fff, 16'h0002, 16'h8000, 16'h5555};
  logic [15:0] dy [4] = '{16'h8000, 16'hfffe, 16'h0001, 16'h5555};
  logic [15:0] edge_v [4] = '{16'h0000, 16'hffff, 16'h8000, 16'h7fff};

  initial begin
    rst = 1'b1; start = 1'b0; x = 16'h0; y = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases, the first taken on the edge right after reset falls.
    start = 1'b1; x = dx[0]; y = dy[0];
    sb.push_back(model(dx[0], dy[0], cyc + 6));
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int i = 1; i < 4; i++) do_op(dx[i], dy[i]);

    // Start re-pulsed two cycles into an operation must be ignored.
    @(posedge clk); #1;
    x = 16'h0010; y = 16'h0001; start = 1'b1;
    sb.push_back(model(16'h0010, 16'h0001, cyc + 6));
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    x = 16'hffff; y = 16'h0000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Reset in the second CALC cycle aborts; restart right after reset.
    @(posedge clk); #1;
    x = 16'h1234; y = 16'h0101; start = 1'b1;
    sb.push_back(model(16'h1234, 16'h0101, cyc + 6));
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    x = 16'h4321; y = 16'h8765; start = 1'b1;
    sb.push_back(model(16'h4321, 16'h8765, cyc + 6));
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Back-to-back with start held high: one accept per 6 cycles.
    begin
      logic [15:0] a, b;
      a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      x = a; y = b; start = 1'b1;
      sb.push_back(model(a, b, cyc + 6));
      @(posedge clk); #1;
      for (int i = 1; i < 4; i++) begin
        a = 16'($urandom); b = 16'($urandom);
        x = a; y = b;
        sb.push_back(model(a, b, cyc + 11));
        repeat (6) @(posedge clk);
        #1;
      end
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
    end

    // Boundary operand combinations.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        do_op(edge_v[i], edge_v[j]);

    // Random operations.
    for (int i = 0; i < 40; i++) do_op(16'($urandom), 16'($urandom));

    repeat (10) @(posedge clk);
    #1;
    check("pending_dones", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_16b_serial.md
SUB_16B_SERIAL -- requirements
Module: sub_16b_serial

Interface
REQ-001 Clocking: the block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  Rising-edge clock for all state.
REQ-003 rst  input  1  Synchronous, active-high reset.
REQ-004 start  input  1  Request to begin an operation; sampled only in IDLE.
REQ-005 x  input  16  Minuend; captured on the accepted start edge.
REQ-006 y  input  16  Subtrahend; captured on the accepted start edge.
REQ-007 z  output  16  Registered result x-y mod 2^16.
REQ-008 sign  output  1  z[15].
REQ-009 zero  output  1  High when z==16'h0000.
REQ-010 carry  output  1  Borrow out; high when x<y unsigned.
REQ-011 parity  output  1  Even-parity flag: XNOR-reduce of z (1 for an even count of ones).
REQ-012 overflow  output  1  Signed overflow: (x[15]!=y[15]) && (z[15]!=x[15]).
REQ-013 busy  output  1  High in CALC and DONE states.
REQ-014 done  output  1  One-cycle pulse; result and flags are valid.

Function
REQ-015 FSM states: the block SHALL implement IDLE, CALC and DONE, with 2-bit state encoding.
REQ-016 IDLE: start=1 at an edge SHALL capture x and y into internal operand registers, clear nibble counter cnt (2 bits) and borrow, then go to CALC.
REQ-017 CALC: each edge SHALL compute one 4-bit nibble, cnt 0..3, LSB nibble first: nib = xr[4cnt+3:4cnt] - yr[4cnt+3:4cnt] - borrow. The nibble SHALL be stored and the new borrow registered.
REQ-018 CALC exit: on the edge where cnt==3, the block SHALL move to DONE.
REQ-019 DONE: on the DONE edge the block SHALL update z and all five flags together, assert done for exactly that following cycle, and return to IDLE.
REQ-020 Latency: if start is accepted at edge N, done SHALL be high during the cycle after edge N+5, and busy SHALL be high from after edge N until done falls.
REQ-021 Start during operation: start while busy SHALL be ignored, with no operand capture and no effect on the in-flight result.
REQ-022 Back-to-back: start held high continuously SHALL begin a new operation on the first IDLE edge after done, giving one accepted start per 6 cycles.
REQ-023 Output hold: z and flags SHALL hold their last values between done pulses. Changes on x or y after capture SHALL NOT affect the result.
REQ-024 Flag derivation: all flags SHALL be computed from the complete 16-bit result and the captured operands, never from partial nibbles.
REQ-025 Wrap-around: results SHALL wrap modulo 2^16, with carry reporting the borrow out of bit 15.

Reset
REQ-026 Reset values: rst=1 at an edge SHALL force IDLE, with cnt=0, borrow=0, operands=0, z=16'h0000, sign=0, zero=0, carry=0, parity=0, overflow=0, busy=0 and done=0.
REQ-027 Reset priority: rst SHALL take priority over start and over any state. Reset in CALC or DONE SHALL abort without producing a done pulse.
REQ-028 After reset: the block SHALL accept start on the first edge after rst deasserts.

Verification
REQ-029 The bench SHALL cover x=16'h8fff, y=16'h8000, start pulse.
  -> z=16'h0fff, sign=0, zero=0, carry=0, parity=1, overflow=0, done 6 cycles after start edge.
REQ-030 The bench SHALL cover x=16'h0002, y=16'hfffe.
  -> z=16'h0004, carry=1, sign=0, zero=0, parity=0, overflow=0.
REQ-031 The bench SHALL cover x=16'h8000, y=16'h0001.
  -> z=16'h7fff, overflow=1, sign=0, carry=0, parity=0.
REQ-032 The bench SHALL cover x=16'h5555, y=16'h5555.
  -> z=16'h0000, zero=1, parity=1, carry=0, overflow=0, sign=0.
REQ-033 The bench SHALL cover start re-pulsed with x=16'hffff, y=16'h0000 two cycles into an operation on 16'h0010-16'h0001.
  -> a single done with z=16'h000f, and no second done.
REQ-034 The bench SHALL cover rst asserted in the second CALC cycle.
  -> no done pulse, all outputs 0, and a new start accepted on the next edge after rst falls.
